rv32_mul_div_unit: RTL and testbench

Multi-cycle RV32M execution unit. Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation at a time and returns a 32-bit result together with the originating instruction word. It sits beside the ALU in execute and feeds the writeback stage's `mul_div_result_i` / `mul_div_instr_i` inputs, which writeback selects with `instr_source_i = 1` and `result_source_i = 3'b011`. Multiplies complete in 2 cycles and divides in 33 cycles; results are held until writeback acknowledges them.

---
 rtl/rv32_mul_div_unit_if.sv | 32 +++
 rtl/rv32_mul_div_unit.sv | 145 ++++++++++++++
 tb/tb_rv32_mul_div_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_mul_div_unit_if.sv
// rv32_mul_div_unit_if
//   Request/result bundle between execute and the multi-cycle RV32M unit.
//   master: issuing side (execute/writeback control), slave: the unit.
//   start_i/op_i/rs1_i/rs2_i/instr_i : request, funct3, operands, instr word
//   flush_i                          : abort operation in flight
//   ack_i                            : writeback consumed the result
//   ready_o/busy_o/valid_o           : idle / in flight or pending / result valid
//   result_o/instr_o                 : 32-bit result and its instruction word
interface rv32_mul_div_unit_if;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [31:0] instr_i;
  logic        flush_i;
  logic        ack_i;
  logic        ready_o;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [31:0] instr_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, instr_i, flush_i, ack_i,
    input  ready_o, busy_o, valid_o, result_o, instr_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, instr_i, flush_i, ack_i,
    output ready_o, busy_o, valid_o, result_o, instr_o
  );
endinterface

// File: rtl/rv32_mul_div_unit.sv
// rv32_mul_div_unit
//   Multi-cycle RV32M execution unit: MUL/MULH/MULHSU/MULHU in 2 cycles,
//   DIV/DIVU/REM/REMU in 33 cycles (radix-2 restoring on magnitudes),
//   divide-by-zero and signed overflow resolved at accept. Result held
//   until acknowledged.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : request/result bundle (slave side), see rv32_mul_div_unit_if
module rv32_mul_div_unit (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  rv32_mul_div_unit_if.slave        bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] result_q, result_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        div_signed;
  logic [31:0] b_mag;
  logic [32:0] a_ext, b_ext;
  logic [63:0] prod;
  logic [32:0] shifted;
  logic        sub_ok;
  logic [31:0] q_fin, r_fin;

  // Datapath shared by MUL and DIV states; operands come only from flops.
  always_comb begin
    // op_q = funct3[1:0]: MULH(01) signs both, MULHSU(10) signs A only.
    a_ext = {(op_q == 2'b01 || op_q == 2'b10) & a_q[31], a_q};
    b_ext = {(op_q == 2'b01) & b_q[31], b_q};
    prod  = $signed({{31{a_ext[32]}}, a_ext}) * $signed({{31{b_ext[32]}}, b_ext});

    div_signed = ~op_q[0];
    b_mag      = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
    // Partial remainder is always below the divisor, so 33 bits suffice.
    shifted    = {rem_q, quo_q[31]};
    sub_ok     = (shifted >= {1'b0, b_mag});
    r_fin      = sub_ok ? 32'(shifted - {1'b0, b_mag}) : shifted[31:0];
    q_fin      = {quo_q[30:0], sub_ok};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    instr_d  = instr_q;
    result_d = result_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;

    if (bus.flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            op_d    = bus.op_i[1:0];
            a_d     = bus.rs1_i;
            b_d     = bus.rs2_i;
            instr_d = bus.instr_i;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = (!bus.op_i[0] && bus.rs1_i[31]) ? (32'd0 - bus.rs1_i) : bus.rs1_i;
            if (!bus.op_i[2]) begin
              state_d = ST_MUL;
            end else if (bus.rs2_i == '0) begin
              result_d = bus.op_i[1] ? bus.rs1_i : '1;
              state_d  = ST_DONE;
            end else if (!bus.op_i[0] && bus.rs1_i == 32'h8000_0000 && bus.rs2_i == '1) begin
              result_d = bus.op_i[1] ? '0 : 32'h8000_0000;
              state_d  = ST_DONE;
            end else begin
              state_d = ST_DIV;
            end
          end
        end
        ST_MUL: begin
          result_d = (op_q == 2'b00) ? prod[31:0] : prod[63:32];
          state_d  = ST_DONE;
        end
        ST_DIV: begin
          quo_d = q_fin;
          rem_d = r_fin;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            // op_q[1]: remainder; sign follows A, quotient sign is A^B.
            if (op_q[1])
              result_d = (div_signed && a_q[31]) ? (32'd0 - r_fin) : r_fin;
            else
              result_d = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - q_fin) : q_fin;
            cnt_d   = '0;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.ack_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      instr_q  <= '0;
      result_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.ready_o  = (state_q == ST_IDLE);
  assign bus.busy_o   = (state_q != ST_IDLE);
  assign bus.valid_o  = (state_q == ST_DONE);
  assign bus.result_o = result_q;
  assign bus.instr_o  = instr_q;

endmodule

// File: tb/tb_rv32_mul_div_unit.sv
// tb_rv32_mul_div_unit
//   Scoreboard bench for rv32_mul_div_unit: expected result/instr pairs are
//   queued at issue and compared when valid_o rises.
module tb_rv32_mul_div_unit;

  logic clk;
  logic rst_n;
  rv32_mul_div_unit_if bus ();

  rv32_mul_div_unit dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb_v;
    longint unsigned ua, ub, pu;
    longint          ps;
    int              ia, ib;
    logic [31:0]     r;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    ia   = $signed(a);
    ib   = $signed(b);
    r    = '0;
    case (op)
      3'd0: begin ps = sa * sb_v;         r = ps[31:0];  end
      3'd1: begin ps = sa * sb_v;         r = ps[63:32]; end
      3'd2: begin ps = sa * longint'(ub); r = ps[63:32]; end
      3'd3: begin pu = ua * ub;           r = pu[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Drive a request at the current edge E0 (called #1 after it).
  task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] instr);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    bus.instr_i = instr;
  endtask

  // Issue, wait for valid with a bound, check latency and scoreboard head.
  task automatic issue_wait(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] instr, input int lat, input string tag);
    int   k;
    exp_t e;
    sb.push_back('{result: model(op, a, b), instr: instr});
    drive_start(op, a, b, instr);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) bus.start_i = 1'b0;
      if (bus.valid_o) break;
    end
    check({tag, "_lat"}, 32'(k), 32'(lat));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_res"}, bus.result_o, e.result);
      check({tag, "_instr"}, bus.instr_o, e.instr);
    end
  endtask

  task automatic do_ack(input string tag);
    bus.ack_i = 1'b1;
    @(posedge clk); #1;
    bus.ack_i = 1'b0;
    check({tag, "_ack_valid"}, 32'(bus.valid_o), 32'd0);
    check({tag, "_ack_ready"}, 32'(bus.ready_o), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_res;
    logic [31:0] held_instr;
    int          vcount;

    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.op_i    = '0;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    bus.instr_i = '0;
    bus.flush_i = 1'b0;
    bus.ack_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  32'(bus.ready_o), 32'd1);
    check("rst_busy",   32'(bus.busy_o),  32'd0);
    check("rst_valid",  32'(bus.valid_o), 32'd0);
    check("rst_result", bus.result_o,     32'd0);
    check("rst_instr",  bus.instr_o,      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MUL family on -2 x 3
    for (int op = 0; op < 4; op++) begin
      issue_wait(3'(op), 32'hFFFF_FFFE, 32'h0000_0003, 32'h0200_0033 | (32'(op) << 12), 2, "mul");
      do_ack("mul");
    end

    // DIV family on -7 / 2
    for (int op = 4; op < 8; op++) begin
      issue_wait(3'(op), 32'hFFFF_FFF9, 32'h0000_0002, 32'h0220_80B3 | (32'(op) << 12), 33, "div");
      do_ack("div");
    end

    // Special cases resolved at accept
    issue_wait(3'd4, 32'h1234_5678, 32'h0, 32'hAAAA_0001, 1, "dz_div");   do_ack("dz_div");
    issue_wait(3'd7, 32'h1234_5678, 32'h0, 32'hAAAA_0002, 1, "dz_remu");  do_ack("dz_remu");
    issue_wait(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'hAAAA_0003, 1, "ovf_div"); do_ack("ovf_div");
    issue_wait(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'hAAAA_0004, 1, "ovf_rem"); do_ack("ovf_rem");

    // A few extra operand patterns through the scoreboard
    issue_wait(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hBBBB_0001, 33, "divu_big"); do_ack("divu_big");
    issue_wait(3'd4, 32'h8000_0000, 32'h0000_0002, 32'hBBBB_0002, 33, "div_min");  do_ack("div_min");
    issue_wait(3'd6, 32'h0000_0064, 32'hFFFF_FFF9, 32'hBBBB_0003, 33, "rem_negb"); do_ack("rem_negb");
    issue_wait(3'd1, 32'h8000_0000, 32'h8000_0000, 32'hBBBB_0004, 2, "mulh_min");  do_ack("mulh_min");
    issue_wait(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hBBBB_0005, 2, "mulhu_max"); do_ack("mulhu_max");

    // Hold ack low: result stable, busy high, extra start ignored
    issue_wait(3'd5, 32'd1000, 32'd7, 32'hCCCC_0001, 33, "hold");
    held_res   = bus.result_o;
    held_instr = bus.instr_o;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) drive_start(3'd0, 32'd5, 32'd6, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      check("hold_res",   bus.result_o,     held_res);
      check("hold_instr", bus.instr_o,      held_instr);
      check("hold_busy",  32'(bus.busy_o),  32'd1);
      check("hold_valid", 32'(bus.valid_o), 32'd1);
    end
    do_ack("hold");
    issue_wait(3'd0, 32'd12345, 32'd678, 32'hCCCC_0002, 2, "b2b");
    do_ack("b2b");

    // Flush in DIV iteration 10
    drive_start(3'd4, 32'd1000, 32'd3, 32'hEEEE_0001);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check("flush_ready", 32'(bus.ready_o), 32'd1);
    check("flush_busy",  32'(bus.busy_o),  32'd0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.valid_o) vcount++;
    end
    check("flush_novalid", 32'(vcount), 32'd0);

    // Flush together with start in IDLE: nothing accepted
    drive_start(3'd0, 32'd3, 32'd4, 32'hEEEE_0002);
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    check("flstart_ready", 32'(bus.ready_o), 32'd1);
    check("flstart_busy",  32'(bus.busy_o),  32'd0);
    check("flstart_instr", bus.instr_o,      32'hEEEE_0001);

    // Async reset mid-divide (iteration 20)
    drive_start(3'd5, 32'hFFFF_0000, 32'd5, 32'hEEEE_0003);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_ready",  32'(bus.ready_o), 32'd1);
    check("arst_busy",   32'(bus.busy_o),  32'd0);
    check("arst_valid",  32'(bus.valid_o), 32'd0);
    check("arst_result", bus.result_o,     32'd0);
    check("arst_instr",  bus.instr_o,      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue_wait(3'd5, 32'd100, 32'd7, 32'hEEEE_0004, 33, "post_rst");
    check("post_rst_const", bus.result_o, 32'd14);
    do_ack("post_rst");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
